// File: rtl/spi_pkg.sv
// Shared types and constants for the SPI target shift engine.
package spi_pkg;

    // Bus mode latched at the start of each frame.
    typedef struct packed {
        logic cpol;
        logic cpha;
    } spi_mode_t;

    // Frame-level state of the target.
    typedef enum logic {
        IDLE   = 1'b0,
        ACTIVE = 1'b1
    } spi_tgt_state_e;

    // Flip-flop depth used to bring the pad signals into the clk_i domain.
    localparam int SPI_SYNC_STAGES = 2;

endpackage

// File: rtl/spi_sync.sv
// N-stage single-bit synchroniser with a configurable reset value.
module spi_sync #(
    parameter int   STAGES  = 2,
    parameter logic RST_VAL = 1'b0
) (
    input  logic clk,
    input  logic rst_n,
    input  logic d,
    output logic q
);

    logic [STAGES-1:0] stages;

    // Shift the asynchronous input through the synchroniser chain.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            stages <= {STAGES{RST_VAL}};
        end else begin
            stages <= {stages[STAGES-2:0], d};
        end
    end

    assign q = stages[STAGES-1];

endmodule

// File: rtl/spi_tgt_core.sv
// SPI target shift engine: oversampled SCLK/CS_N/MOSI, valid/ready RX and
// TX word streams. Build option SPI_TGT_LSB_FIRST_EN switches both shift
// directions to LSB first; without it words are shifted MSB first.
//
// Handshakes: a word moves on tx_* / rx_* in every clk_i cycle where valid
// and ready are both high at the rising edge; valid never depends on ready.
module spi_tgt_core
    import spi_pkg::*;
#(
    parameter int                    DATA_WIDTH = 8,
    parameter logic [DATA_WIDTH-1:0] TX_IDLE    = {DATA_WIDTH{1'b1}}
) (
    input  logic                  clk_i,
    input  logic                  rst_ni,
    input  logic                  cpol_i,
    input  logic                  cpha_i,
    input  logic                  sclk_i,
    input  logic                  cs_ni,
    input  logic                  mosi_i,
    output logic                  miso_o,
    output logic                  miso_oe_o,
    input  logic [DATA_WIDTH-1:0] tx_data_i,
    input  logic                  tx_valid_i,
    output logic                  tx_ready_o,
    output logic [DATA_WIDTH-1:0] rx_data_o,
    output logic                  rx_valid_o,
    input  logic                  rx_ready_i,
    output logic                  busy_o,
    output logic                  overrun_o,
    output logic                  underrun_o
);

    localparam int               CNT_W    = $clog2(DATA_WIDTH);
    localparam logic [CNT_W-1:0] LAST_BIT = CNT_W'(DATA_WIDTH - 1);

    spi_tgt_state_e        state;
    spi_mode_t             mode;
    logic [CNT_W-1:0]      bit_cnt;
    logic [DATA_WIDTH-1:0] rx_shift;
    logic [DATA_WIDTH-1:0] tx_shift;
    logic [DATA_WIDTH-1:0] tx_buf;
    logic                  tx_full;

    logic sclk_s, cs_s, mosi_s;
    logic sclk_q, cs_q;

    // CS_N resets to the deselected level so reset release never looks like a frame start.
    spi_sync #(.STAGES(SPI_SYNC_STAGES), .RST_VAL(1'b0)) u_sync_sclk (
        .clk(clk_i), .rst_n(rst_ni), .d(sclk_i), .q(sclk_s)
    );
    spi_sync #(.STAGES(SPI_SYNC_STAGES), .RST_VAL(1'b1)) u_sync_cs (
        .clk(clk_i), .rst_n(rst_ni), .d(cs_ni), .q(cs_s)
    );
    spi_sync #(.STAGES(SPI_SYNC_STAGES), .RST_VAL(1'b0)) u_sync_mosi (
        .clk(clk_i), .rst_n(rst_ni), .d(mosi_i), .q(mosi_s)
    );

    // Delayed copies of the synced pins used for edge detection.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            sclk_q <= 1'b0;
            cs_q   <= 1'b1;
        end else begin
            sclk_q <= sclk_s;
            cs_q   <= cs_s;
        end
    end

    logic cs_fall, cs_rise, lead_edge, trail_edge, in_frame;
    logic sample_edge, shift_edge, word_load, word_shift, word_done, tx_push;
    logic [DATA_WIDTH-1:0] load_word, rx_next, tx_next;
    logic load_bit, next_bit;

    assign cs_fall     = cs_q & ~cs_s;
    assign cs_rise     = ~cs_q & cs_s;
    assign lead_edge   = (sclk_q == mode.cpol) && (sclk_s != mode.cpol);
    assign trail_edge  = (sclk_q != mode.cpol) && (sclk_s == mode.cpol);
    // A deselect in the same cycle as an SCLK edge wins; the edge is dropped.
    assign in_frame    = (state == ACTIVE) && !cs_rise;
    assign sample_edge = in_frame && (mode.cpha ? trail_edge : lead_edge);
    assign shift_edge  = in_frame && (mode.cpha ? lead_edge : trail_edge);
    // CPHA=0 must present the first bit before the first SCLK edge, so load at select.
    assign word_load   = ((state == IDLE) && cs_fall && !cpha_i)
                       || (shift_edge && (bit_cnt == '0));
    assign word_shift  = shift_edge && (bit_cnt != '0);
    assign word_done   = sample_edge && (bit_cnt == LAST_BIT);
    assign tx_push     = tx_valid_i && !tx_full;
    assign load_word   = tx_full ? tx_buf : TX_IDLE;

`ifdef SPI_TGT_LSB_FIRST_EN
    assign rx_next  = {mosi_s, rx_shift[DATA_WIDTH-1:1]};
    assign tx_next  = {1'b0, tx_shift[DATA_WIDTH-1:1]};
    assign load_bit = load_word[0];
    assign next_bit = tx_next[0];
`else
    assign rx_next  = {rx_shift[DATA_WIDTH-2:0], mosi_s};
    assign tx_next  = {tx_shift[DATA_WIDTH-2:0], 1'b0};
    assign load_bit = load_word[DATA_WIDTH-1];
    assign next_bit = tx_next[DATA_WIDTH-1];
`endif

    // Frame FSM: select/deselect, mode latch, bit counting and RX deserialisation.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state     <= IDLE;
            mode      <= '0;
            bit_cnt   <= '0;
            miso_oe_o <= 1'b0;
            rx_shift  <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (cs_fall) begin
                        state     <= ACTIVE;
                        mode      <= {cpol_i, cpha_i};
                        bit_cnt   <= '0;
                        miso_oe_o <= 1'b1;
                        rx_shift  <= '0;
                    end
                end
                ACTIVE: begin
                    if (cs_rise) begin
                        // Partial words are thrown away with the frame.
                        state     <= IDLE;
                        miso_oe_o <= 1'b0;
                        bit_cnt   <= '0;
                        rx_shift  <= '0;
                    end else if (sample_edge) begin
                        rx_shift <= rx_next;
                        bit_cnt  <= (bit_cnt == LAST_BIT) ? '0 : bit_cnt + 1'b1;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

    // TX holding register and MISO shifter; a load always takes the old buffer contents.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            tx_buf     <= '0;
            tx_full    <= 1'b0;
            tx_shift   <= '0;
            miso_o     <= 1'b0;
            underrun_o <= 1'b0;
        end else begin
            underrun_o <= 1'b0;
            if (word_load) begin
                tx_shift   <= load_word;
                miso_o     <= load_bit;
                underrun_o <= !tx_full;
                tx_full    <= 1'b0;
            end else if (word_shift) begin
                tx_shift <= tx_next;
                miso_o   <= next_bit;
            end
            if (tx_push) begin
                tx_buf  <= tx_data_i;
                tx_full <= 1'b1;
            end
        end
    end

    // RX output register: present completed words, flag words lost to a full output.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            rx_data_o  <= '0;
            rx_valid_o <= 1'b0;
            overrun_o  <= 1'b0;
        end else begin
            overrun_o <= 1'b0;
            if (word_done) begin
                if (!rx_valid_o || rx_ready_i) begin
                    rx_data_o  <= rx_next;
                    rx_valid_o <= 1'b1;
                end else begin
                    overrun_o <= 1'b1;
                end
            end else if (rx_valid_o && rx_ready_i) begin
                rx_valid_o <= 1'b0;
            end
        end
    end

    assign tx_ready_o = !tx_full;
    assign busy_o     = (state == ACTIVE);

endmodule

// File: tb/tb_spi_tgt_core.sv
// Testbench for spi_tgt_core: an SPI controller model drives frames, a
// monitor collects RX handshakes and status pulses, and results are compared
// against words and counts derived from the frame description.
module tb_spi_tgt_core;

  localparam int W = 8;
  localparam int H = 8;  // SCLK half period in clk cycles

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic cpol = 1'b0, cpha = 1'b0;
  logic sclk = 1'b0, cs_n = 1'b1, mosi = 1'b0;
  logic [W-1:0] tx_data = '0;
  logic tx_valid = 1'b0;
  logic rx_ready = 1'b0;
  logic miso_o, miso_oe_o, tx_ready_o, rx_valid_o, busy_o, overrun_o, underrun_o;
  logic [W-1:0] rx_data_o;

  spi_tgt_core #(.DATA_WIDTH(W)) dut (
    .clk_i(clk), .rst_ni(rst_n), .cpol_i(cpol), .cpha_i(cpha),
    .sclk_i(sclk), .cs_ni(cs_n), .mosi_i(mosi),
    .miso_o(miso_o), .miso_oe_o(miso_oe_o),
    .tx_data_i(tx_data), .tx_valid_i(tx_valid), .tx_ready_o(tx_ready_o),
    .rx_data_o(rx_data_o), .rx_valid_o(rx_valid_o), .rx_ready_i(rx_ready),
    .busy_o(busy_o), .overrun_o(overrun_o), .underrun_o(underrun_o)
  );

  // clock / cycle counter
  always #5 clk = ~clk;
  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  // scoreboard counters
  int n_checks = 0;
  int n_pass = 0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs === exp) n_pass++;
    else $display("FAIL %s: observed %0h expected %0h", tag, obs, exp);
  endtask

  // monitor: consumer ready policy, accepted words, pulse counts
  logic [W-1:0] got_q[$];
  int rdy_mode = 0;  // 0 hold low, 1 random, 2 always high
  int n_over = 0, n_under = 0;
  logic prev_valid = 1'b0;
  int rise_cyc = 0;
  int last_sample_cyc = 0;

  always @(negedge clk) begin
    case (rdy_mode)
      0: rx_ready = 1'b0;
      1: rx_ready = 1'($urandom_range(0, 1));
      default: rx_ready = 1'b1;
    endcase
    if (rx_valid_o && rx_ready) got_q.push_back(rx_data_o);
    if (overrun_o) n_over++;
    if (underrun_o) n_under++;
    if (rx_valid_o && !prev_valid) rise_cyc = cyc;
    prev_valid = rx_valid_o;
  end

  // frame description
  logic [W-1:0] f_mosi[4];
  logic [W-1:0] f_tx[4];
  bit f_has[4];
  logic [W-1:0] f_miso[4];

  task automatic wait_cyc(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic push_tx(input logic [W-1:0] d);
    check("tx_ready_before_push", tx_ready_o, 1);
    tx_data = d;
    tx_valid = 1'b1;
    @(negedge clk);
    tx_valid = 1'b0;
  endtask

  // half SCLK period; refill the TX buffer for the next word mid-word
  task automatic half_push(input int w, input int b, input int n);
    if (b == 3 && w + 1 < n && f_has[w+1]) begin
      push_tx(f_tx[w+1]);
      wait_cyc(H - 1);
    end else begin
      wait_cyc(H);
    end
  endtask

  // controller model: n words, stop after 'cut' bits when cut > 0
  task automatic frame(input bit fpol, input bit fpha, input int n, input int cut);
    int cnt;
    bit stop;
    int bi;
    cnt = 0;
    stop = 0;
    cpol = fpol;
    cpha = fpha;
    sclk = fpol;
    mosi = 1'b0;
    wait_cyc(4);
    if (f_has[0]) push_tx(f_tx[0]);
    cs_n = 1'b0;
    wait_cyc(H);
    check("busy_in_frame", busy_o, 1);
    check("oe_in_frame", miso_oe_o, 1);
    for (int w = 0; w < n && !stop; w++) begin
      f_miso[w] = '0;
      for (int b = 0; b < W && !stop; b++) begin
`ifdef SPI_TGT_LSB_FIRST_EN
        bi = b;
`else
        bi = W - 1 - b;
`endif
        if (!fpha) begin
          mosi = f_mosi[w][bi];
          wait_cyc(H);
          sclk = ~fpol;
          f_miso[w][bi] = miso_o;
          last_sample_cyc = cyc;
          half_push(w, b, n);
          sclk = fpol;
        end else begin
          sclk = ~fpol;
          mosi = f_mosi[w][bi];
          half_push(w, b, n);
          sclk = fpol;
          f_miso[w][bi] = miso_o;
          last_sample_cyc = cyc;
          wait_cyc(H);
        end
        cnt++;
        if (cnt == cut) stop = 1;
      end
    end
    wait_cyc(H);
    cs_n = 1'b1;
    wait_cyc(2 * H);
    check("busy_after_frame", busy_o, 0);
    check("oe_after_frame", miso_oe_o, 0);
  endtask

  task automatic check_reset_outputs(input string tag);
    check({tag, "_miso"}, miso_o, 0);
    check({tag, "_oe"}, miso_oe_o, 0);
    check({tag, "_tx_ready"}, tx_ready_o, 1);
    check({tag, "_rx_data"}, rx_data_o, 0);
    check({tag, "_rx_valid"}, rx_valid_o, 0);
    check({tag, "_busy"}, busy_o, 0);
    check({tag, "_overrun"}, overrun_o, 0);
    check({tag, "_underrun"}, underrun_o, 0);
  endtask

  int u0, o0, misses;

  initial begin
    // reset
    wait_cyc(3);
    check_reset_outputs("reset");
    rst_n = 1'b1;
    wait_cyc(4);

    // mode 0, single word, TX preloaded
    got_q.delete();
    rdy_mode = 0;
    u0 = n_under;
    f_has[0] = 1; f_tx[0] = 8'hA5; f_mosi[0] = 8'h3C;
    frame(0, 0, 1, 0);
    check("m0_miso", f_miso[0], 8'hA5);
    check("m0_rx_valid", rx_valid_o, 1);
    check("m0_rx_data", rx_data_o, 8'h3C);
    check("m0_rx_latency_ok", 32'((rise_cyc - last_sample_cyc) inside {3, 4}), 1);
    check("m0_underrun_end_load", n_under - u0, 1);
    rdy_mode = 2;
    wait_cyc(4);
    check("m0_got_size", got_q.size(), 1);
    if (got_q.size() > 0) check("m0_got", got_q[0], 8'h3C);

    // mode 3, two back-to-back words
    got_q.delete();
    u0 = n_under;
    f_has[0] = 1; f_tx[0] = 8'h12; f_mosi[0] = 8'hF0;
    f_has[1] = 1; f_tx[1] = 8'h34; f_mosi[1] = 8'h0F;
    frame(1, 1, 2, 0);
    check("m3_miso0", f_miso[0], 8'h12);
    check("m3_miso1", f_miso[1], 8'h34);
    check("m3_got_size", got_q.size(), 2);
    if (got_q.size() == 2) begin
      check("m3_got0", got_q[0], 8'hF0);
      check("m3_got1", got_q[1], 8'h0F);
    end
    check("m3_underrun", n_under - u0, 0);

    // empty TX buffer -> idle pattern
    got_q.delete();
    u0 = n_under;
    f_has[0] = 0; f_mosi[0] = 8'h5E;
    frame(0, 1, 1, 0);
    check("ur_miso", f_miso[0], 8'hFF);
    check("ur_count", n_under - u0, 1);
    check("ur_tx_ready", tx_ready_o, 1);

    // consumer stalled across two words
    got_q.delete();
    rdy_mode = 0;
    o0 = n_over;
    f_has[0] = 1; f_tx[0] = 8'h5A; f_mosi[0] = 8'h11;
    f_has[1] = 1; f_tx[1] = 8'hC3; f_mosi[1] = 8'h22;
    frame(0, 0, 2, 0);
    check("ov_rx_data", rx_data_o, 8'h11);
    check("ov_rx_valid", rx_valid_o, 1);
    check("ov_count", n_over - o0, 1);
    check("ov_miso1", f_miso[1], 8'hC3);
    rdy_mode = 2;
    wait_cyc(4);
    check("ov_got_size", got_q.size(), 1);
    if (got_q.size() > 0) check("ov_got", got_q[0], 8'h11);

    // partial frame, then a clean frame
    got_q.delete();
    f_has[0] = 0; f_mosi[0] = 8'hB7;
    frame(0, 0, 1, 5);
    check("part_no_word", got_q.size(), 0);
    check("part_rx_valid", rx_valid_o, 0);
    f_has[0] = 1; f_tx[0] = 8'hC3; f_mosi[0] = 8'h81;
    frame(0, 0, 1, 0);
    check("part_next_miso", f_miso[0], 8'hC3);
    check("part_next_size", got_q.size(), 1);
    if (got_q.size() > 0) check("part_next_got", got_q[0], 8'h81);

    // randomized frames
    for (int it = 0; it < 8; it++) begin
      bit rp, rh;
      int n;
      rp = 1'($urandom_range(0, 1));
      rh = 1'($urandom_range(0, 1));
      n = $urandom_range(1, 3);
      misses = 0;
      for (int w = 0; w < 4; w++) begin
        f_mosi[w] = W'($urandom);
        f_tx[w] = W'($urandom);
        f_has[w] = ($urandom_range(0, 3) != 0);
        if (w < n && !f_has[w]) misses++;
      end
      got_q.delete();
      rdy_mode = 1;
      u0 = n_under;
      o0 = n_over;
      frame(rp, rh, n, 0);
      wait_cyc(20);
      for (int w = 0; w < n; w++)
        check("rnd_miso", f_miso[w], f_has[w] ? f_tx[w] : 8'hFF);
      check("rnd_got_size", got_q.size(), n);
      for (int w = 0; w < n && w < got_q.size(); w++)
        check("rnd_got", got_q[w], f_mosi[w]);
      check("rnd_underrun", n_under - u0, misses + (rh ? 0 : 1));
      check("rnd_overrun", n_over - o0, 0);
    end

    // asynchronous reset in the middle of a word
    rdy_mode = 2;
    f_has[0] = 0; f_mosi[0] = 8'hE7; f_mosi[1] = 8'h18;
    fork
      frame(0, 0, 2, 4);
      begin
        wait_cyc(40);
        #2;
        rst_n = 1'b0;
        #1;
        check_reset_outputs("midrst");
      end
    join
    wait_cyc(2);
    rst_n = 1'b1;
    wait_cyc(4);
    got_q.delete();
    f_has[0] = 1; f_tx[0] = 8'h6B; f_mosi[0] = 8'h55;
    frame(0, 1, 1, 0);
    check("post_rst_miso", f_miso[0], 8'h6B);
    check("post_rst_size", got_q.size(), 1);
    if (got_q.size() > 0) check("post_rst_got", got_q[0], 8'h55);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
